// File: rtl/nap_countdown.sv
// nap_countdown: BCD m:ss countdown timer with an auto-clearing alarm.
// A keypad setting is loaded in IDLE, counted down once per second in RUN,
// and announced in ALARM for ALARM_SECS seconds or until stop.
//
// Handshake: there is no valid/ready pair here. load is a level qualifier
// sampled on each rising edge and acted on only in IDLE; stop is a level that
// wins over load and over any due decrement or timeout in every state.
module nap_countdown #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int ALARM_SECS    = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] one_sec,
    input  logic [3:0] ten_sec,
    input  logic [3:0] one_min,
    input  logic       stop,
    output logic [3:0] cnt_one_sec,
    output logic [3:0] cnt_ten_sec,
    output logic [3:0] cnt_one_min,
    output logic       running,
    output logic       alarm,
    output logic       done,
    output logic [1:0] fsm_state
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [AW-1:0] asec, asec_nxt;
    logic [3:0]    s_nxt, t_nxt, m_nxt;
    logic [3:0]    ld_s, ld_t, ld_m;
    logic          running_nxt, alarm_nxt, done_nxt;
    logic          wrap;

    // Debug view of the FSM state.
    assign fsm_state = state;

    // Out-of-range keypad digits saturate to the largest legal digit.
    assign ld_s = (one_sec > 4'd9) ? 4'd9 : one_sec;
    assign ld_t = (ten_sec > 4'd5) ? 4'd5 : ten_sec;
    assign ld_m = (one_min > 4'd9) ? 4'd9 : one_min;

    // Last cycle of a second.
    assign wrap = (presc == PW'(TICKS_PER_SEC - 1));

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        asec_nxt  = asec;
        s_nxt     = cnt_one_sec;
        t_nxt     = cnt_ten_sec;
        m_nxt     = cnt_one_min;
        case (state)
            IDLE: begin
                presc_nxt = '0;
                asec_nxt  = '0;
                // A 0:00 setting would expire immediately, so it is dropped.
                if (load && !stop && ((ld_s | ld_t | ld_m) != 4'd0)) begin
                    s_nxt     = ld_s;
                    t_nxt     = ld_t;
                    m_nxt     = ld_m;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                    s_nxt     = 4'd0;
                    t_nxt     = 4'd0;
                    m_nxt     = 4'd0;
                end else if (wrap) begin
                    presc_nxt = '0;
                    if (cnt_one_sec != 4'd0) begin
                        s_nxt = cnt_one_sec - 4'd1;
                    end else begin
                        s_nxt = 4'd9;
                        if (cnt_ten_sec != 4'd0) begin
                            t_nxt = cnt_ten_sec - 4'd1;
                        end else begin
                            t_nxt = 4'd5;
                            m_nxt = cnt_one_min - 4'd1;
                        end
                    end
                    // Only 0:01 decrements to 0:00; it never borrows.
                    if (cnt_one_sec == 4'd1 && cnt_ten_sec == 4'd0 &&
                        cnt_one_min == 4'd0) begin
                        state_nxt = ALARM;
                        asec_nxt  = '0;
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            ALARM: begin
                if (stop) begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                end else if (wrap) begin
                    presc_nxt = '0;
                    if (asec == AW'(ALARM_SECS - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        asec_nxt = asec + AW'(1);
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                presc_nxt = '0;
                asec_nxt  = '0;
                s_nxt     = 4'd0;
                t_nxt     = 4'd0;
                m_nxt     = 4'd0;
            end
        endcase
        running_nxt = (state_nxt == RUN);
        alarm_nxt   = (state_nxt == ALARM);
        done_nxt    = (state == RUN) && (state_nxt == ALARM);
    end

    // State, counters and outputs all update together on the rising edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            asec        <= '0;
            cnt_one_sec <= 4'd0;
            cnt_ten_sec <= 4'd0;
            cnt_one_min <= 4'd0;
            running     <= 1'b0;
            alarm       <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            presc       <= presc_nxt;
            asec        <= asec_nxt;
            cnt_one_sec <= s_nxt;
            cnt_ten_sec <= t_nxt;
            cnt_one_min <= m_nxt;
            running     <= running_nxt;
            alarm       <= alarm_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: doc/nap_countdown.md
NAP_COUNTDOWN -- requirements
Module: nap_countdown

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1000, meaning the number of clock cycles per countdown second (minimum 2).
REQ-002 SHALL have parameter ALARM_SECS, default 10, meaning the number of seconds the alarm stays on before it auto-clears (minimum 1).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port load, input, 1 bit: starts the countdown; driven by the keypad stage's completeSetting signal.
REQ-006 SHALL have ports one_sec, ten_sec, one_min, each input, 4 bits: BCD setting digits, sampled only while load=1.
REQ-007 SHALL have port stop, input, 1 bit: user cancel or alarm acknowledge.
REQ-008 SHALL have ports cnt_one_sec, cnt_ten_sec, cnt_one_min, each output, 4 bits: remaining time in BCD.
REQ-009 SHALL have port running, output, 1 bit: high while in the RUN state.
REQ-010 SHALL have port alarm, output, 1 bit: high while in the ALARM state.
REQ-011 SHALL have port done, output, 1 bit: a one-cycle pulse in the first cycle of ALARM.

Function
REQ-012 SHALL implement three states: IDLE, RUN and ALARM; all outputs SHALL be registered.
REQ-013 In IDLE with load=1 and stop=0, SHALL capture the clamped digits into the counters, clear the prescaler, and enter RUN on the same edge.
  - clamp one_sec>9 to 9, ten_sec>5 to 5, one_min>9 to 9.
  - running=1 from the next cycle.
REQ-014 In IDLE, a load whose clamped value is 0:00 SHALL be ignored: stay in IDLE, counters unchanged.
REQ-015 In RUN, the prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap; each wrap SHALL decrement the counters once.
  - The first decrement occurs TICKS_PER_SEC cycles after the load edge.
REQ-016 The decrement SHALL be BCD with borrow:
  - one_sec>0: one_sec-1.
  - otherwise one_sec=9, and ten_sec-1 if ten_sec>0.
  - otherwise also ten_sec=5 and one_min-1.
REQ-017 The decrement that produces 0:00 SHALL move the block to ALARM on the same edge.
  - Next cycle: alarm=1, done=1, running=0, counters read 0:00.
REQ-018 In RUN, stop=1 SHALL return to IDLE on the next edge, clear the counters to 0 and clear the prescaler; stop has priority over a due decrement.
REQ-019 In RUN and ALARM, load SHALL be ignored; a new setting is accepted only in IDLE.
REQ-020 In ALARM, the prescaler SHALL keep counting seconds.
  - After ALARM_SECS seconds, return to IDLE.
  - stop=1 SHALL return to IDLE on the next edge, earlier if asserted before the timeout.
REQ-021 When load=1 and stop=1 arrive in the same cycle, stop SHALL win in every state; in IDLE, no load occurs.
REQ-022 done SHALL be high for exactly one cycle per ALARM entry; alarm SHALL stay high for the whole ALARM state.
REQ-023 An unreachable state encoding SHALL recover to IDLE on the next edge with all outputs cleared.

Reset
REQ-024 When reset=1 at a rising clock edge, the block SHALL enter IDLE.
  - counters and prescaler cleared to 0.
  - running=0, alarm=0, done=0.
REQ-025 Reset SHALL override load and stop, including a reset during RUN or ALARM, with no residual done pulse.
REQ-026 Asynchronous reset behaviour SHALL NOT exist: reset asserted between clock edges SHALL have no effect until the next rising edge.

Verification (TICKS_PER_SEC=4, ALARM_SECS=2)
REQ-027 The bench SHALL cover these directed scenarios:
  - Load 0:05 -> running=1; cnt_one_sec goes 5,4,3,2,1,0 at 4-cycle intervals; done pulses once; alarm=1 for 8 cycles, then IDLE.
  - Load 1:00 -> after one second counters read 0:59; after 60 seconds alarm=1.
  - Load 0:30, then stop during the 3rd second -> IDLE next cycle, counters 0:00, alarm never asserted.
  - Load with one_sec=4'hC, ten_sec=4'h7, one_min=0 -> counters load 0:59; load 0:00 -> ignored, stays IDLE.
  - load=1 during RUN -> ignored; load=1 together with stop=1 in IDLE -> stays IDLE; stop in ALARM -> IDLE on the next edge.
  - reset asserted mid-RUN and mid-ALARM -> all outputs 0 after the edge; reset pulsed between edges -> no effect.
